// File: rtl/z_match_event_monitor.sv
// Z rising-edge monitor: stamps accepted edges with a free-running counter and queues them.
// Optional glitch filter (two-sample qualification) enabled by defining ZMON_GLITCH_FILTER_EN.
module z_match_event_monitor #(
  parameter int unsigned TS_W    = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned HOLDOFF = 3,
  parameter int unsigned DROP_W  = 8
) (
  input  logic                     CK,
  input  logic                     RST_N,
  input  logic                     Z,
  input  logic                     EN,
  input  logic                     CLR,
  input  logic                     OUT_READY,
  output logic                     OUT_VALID,
  output logic [TS_W-1:0]          OUT_TS,
  output logic [$clog2(DEPTH):0]   FIFO_LVL,
  output logic                     OVF,
  output logic [DROP_W-1:0]        DROP_CNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {StIdle, StArmed, StHold} state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              z_q, z_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [TS_W-1:0]   mem_q [DEPTH];

  logic evt, accept, full, empty, pop, push, drop;

`ifdef ZMON_GLITCH_FILTER_EN
  // Z must be seen high on two consecutive samples before it counts as a rise.
  logic zf, zf_q;
  always_comb begin
    zf  = Z & z_q;
    evt = zf & ~zf_q;
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) zf_q <= 1'b1;
    else        zf_q <= zf;
  end
`else
  always_comb begin
    evt = Z & ~z_q;
  end
`endif

  always_comb begin
    ts_d = ts_q + 1'b1;
    z_d  = Z;
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (EN) state_d = StArmed;
      end
      StArmed: begin
        if (evt) begin
          accept = 1'b1;
          if (HOLDOFF != 0) begin
            state_d = StHold;
            hcnt_d  = HW'(HOLDOFF);
          end
        end
      end
      StHold: begin
        hcnt_d = hcnt_q - 1'b1;
        if (hcnt_q <= HW'(1)) state_d = StArmed;
      end
      default: state_d = StIdle;
    endcase
    // Disabling wins over every transition, but an edge this cycle was already accepted.
    if (!EN) state_d = StIdle;
  end

  always_comb begin
    empty    = (lvl_q == '0);
    full     = (lvl_q == LW'(DEPTH));
    pop      = ~empty & OUT_READY;
    push     = accept & (~full | pop);
    drop     = accept & full & ~pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lvl_d    = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      lvl_d = lvl_q + 1'b1;
      else if (pop && !push) lvl_d = lvl_q - 1'b1;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      hcnt_q   <= '0;
      ts_q     <= '0;
      z_q      <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      ts_q     <= ts_d;
      z_q      <= z_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: OUT_TS is masked whenever the FIFO is empty.
  always_ff @(posedge CK) begin
    if (push && !CLR) mem_q[wr_ptr_q] <= ts_q;
  end

  always_comb begin
    OUT_VALID = ~empty;
    OUT_TS    = empty ? '0 : mem_q[rd_ptr_q];
    FIFO_LVL  = lvl_q;
    OVF       = ovf_q;
    DROP_CNT  = drop_q;
  end

endmodule

// File: tb/tb_z_match_event_monitor.sv
// Randomized bench for z_match_event_monitor against a cycle-level event/queue model.
// Small TS_W and DROP_W exercise counter wrap and drop-count saturation quickly.
module tb_z_match_event_monitor;

  localparam int unsigned TS_W    = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned HOLDOFF = 3;
  localparam int unsigned DROP_W  = 4;
  localparam int          DROP_MAX = (1 << DROP_W) - 1;

  logic                    ck = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    z = 1'b0;
  logic                    en = 1'b0;
  logic                    clr = 1'b0;
  logic                    rdy = 1'b0;
  logic                    out_valid;
  logic [TS_W-1:0]         out_ts;
  logic [$clog2(DEPTH):0]  fifo_lvl;
  logic                    ovf;
  logic [DROP_W-1:0]       drop_cnt;

  z_match_event_monitor #(
    .TS_W    (TS_W),
    .DEPTH   (DEPTH),
    .HOLDOFF (HOLDOFF),
    .DROP_W  (DROP_W)
  ) u_dut (
    .CK        (ck),
    .RST_N     (rst_n),
    .Z         (z),
    .EN        (en),
    .CLR       (clr),
    .OUT_READY (rdy),
    .OUT_VALID (out_valid),
    .OUT_TS    (out_ts),
    .FIFO_LVL  (fifo_lvl),
    .OVF       (ovf),
    .DROP_CNT  (drop_cnt)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycle index, stamp counter, last samples, accepted-event bookkeeping.
  int m_cyc;
  int m_ts;
  bit m_zp;
  bit m_zfp;
  bit m_enp;
  bit m_broken;
  int m_last_acc;
  int m_q[$];
  bit m_ovf;
  int m_drop;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc      = 0;
    m_ts       = 0;
    m_zp       = 1'b1;
    m_zfp      = 1'b1;
    m_enp      = 1'b0;
    m_broken   = 1'b1;
    m_last_acc = 0;
    m_q.delete();
    m_ovf      = 1'b0;
    m_drop     = 0;
  endtask

  // One clock of behaviour: an edge is taken only if the monitor was enabled last cycle and
  // no accepted event lies within HOLDOFF cycles with EN held high ever since.
  task automatic model_step();
    bit e;
    bit acc;
    bit pop;
    bit zf;
    zf  = 1'b0;
    pop = (m_q.size() > 0) && rdy;
`ifdef ZMON_GLITCH_FILTER_EN
    zf    = z && m_zp;
    e     = zf && !m_zfp;
    m_zfp = zf;
`else
    e = z && !m_zp;
`endif
    acc = e && m_enp && (m_broken || (m_cyc - m_last_acc) > int'(HOLDOFF));
    if (acc) begin
      m_last_acc = m_cyc;
      m_broken   = 1'b0;
    end
    if (!en) m_broken = 1'b1;
    m_enp = en;
    if (clr) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        if (m_q.size() < int'(DEPTH)) m_q.push_back(m_ts);
        else begin
          m_ovf = 1'b1;
          if (m_drop < DROP_MAX) m_drop++;
        end
      end
    end
    m_zp  = z;
    m_ts  = (m_ts + 1) % (1 << TS_W);
    m_cyc++;
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check_eq("out_ts",    32'(out_ts),    (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check_eq("fifo_lvl",  32'(fifo_lvl),  32'(m_q.size()));
    check_eq("ovf",       32'(ovf),       32'(m_ovf));
    check_eq("drop_cnt",  32'(drop_cnt),  32'(m_drop));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_ts"},    32'(out_ts),    32'd0);
    check_eq({tag, "_lvl"},   32'(fifo_lvl),  32'd0);
    check_eq({tag, "_ovf"},   32'(ovf),       32'd0);
    check_eq({tag, "_drop"},  32'(drop_cnt),  32'd0);
  endtask

  task automatic cycle(input bit zi, input bit eni, input bit clri, input bit rdyi);
    z   = zi;
    en  = eni;
    clr = clri;
    rdy = rdyi;
    model_step();
    @(posedge ck);
    #1;
    check_outputs();
  endtask

  // Independent constant expectations for the hand-written scenarios (raw edge detection).
  task automatic directed_check(input int t);
`ifndef ZMON_GLITCH_FILTER_EN
    case (t)
      10: begin
        check_eq("first_stamp_valid", 32'(out_valid), 32'd1);
        check_eq("first_stamp_ts", 32'(out_ts), 32'd10);
      end
      12: check_eq("holdoff_ignored", 32'(out_valid), 32'd0);
      14: begin
        check_eq("after_holdoff_ts", 32'(out_ts), 32'd14);
        check_eq("holdoff_no_drop", 32'(drop_cnt), 32'd0);
      end
      79: begin
        check_eq("full_lvl", 32'(fifo_lvl), 32'd4);
        check_eq("full_ovf", 32'(ovf), 32'd1);
        check_eq("full_drop", 32'(drop_cnt), 32'd1);
        check_eq("full_head", 32'(out_ts), 32'd30);
      end
      80: begin
        check_eq("full_pop_push_lvl", 32'(fifo_lvl), 32'd4);
        check_eq("full_pop_push_drop", 32'(drop_cnt), 32'd1);
        check_eq("full_pop_push_head", 32'(out_ts), 32'd40);
      end
      83: check_eq("late_entry_order", 32'(out_ts), 32'd80);
      145: begin
        check_eq("clr_lvl", 32'(fifo_lvl), 32'd0);
        check_eq("clr_ovf", 32'(ovf), 32'd0);
        check_eq("clr_drop", 32'(drop_cnt), 32'd0);
      end
      170: check_eq("predrain_lvl", 32'(fifo_lvl), 32'd2);
      default: ;
    endcase
`else
    if (t < 0) $display("unused %0d", t);
`endif
  endtask

  // Called just after a rising edge; asserts reset asynchronously away from any clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;
  endtask

  initial begin
    int zp;
    int rp;
    bit clr_blk;
    bit zi;
    bit eni;
    bit clri;
    bit rdyi;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;

    // Hold-off, overflow, full+pop+push, CLR during overflow, then reset mid-drain.
    for (int t = 0; t < 20; t++) begin
      cycle(t == 10 || t == 12 || t == 14, 1'b1, 1'b0, 1'b1);
      directed_check(t);
    end
    for (int t = 20; t < 96; t++) begin
      cycle((t % 10 == 0) && t >= 30 && t <= 80, 1'b1, 1'b0, t >= 80);
      directed_check(t);
    end
    for (int t = 96; t < 150; t++) begin
      cycle((t % 10 == 0) && t >= 100 && t <= 140, 1'b1, t == 145, 1'b0);
      directed_check(t);
    end
    for (int t = 150; t <= 170; t++) begin
      cycle(t == 150 || t == 155 || t == 160, 1'b1, 1'b0, t == 170);
      directed_check(t);
    end
    async_reset("mid_drain_reset");

    // Randomized blocks with varying Z activity, consumer rate and occasional CLR/EN drops.
    for (int b = 0; b < 20; b++) begin
      zp      = $urandom_range(10, 70);
      rp      = (b % 3 == 0) ? 5 : $urandom_range(20, 100);
      clr_blk = (b % 4 == 1);
      for (int i = 0; i < 200; i++) begin
        zi   = ($urandom_range(0, 99) < zp);
        eni  = ($urandom_range(0, 19) != 0);
        clri = clr_blk && ($urandom_range(0, 49) == 0);
        rdyi = ($urandom_range(0, 99) < rp);
        cycle(zi, eni, clri, rdyi);
      end
      if (b == 9) async_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
